// File: rtl/alu_mul_seq_if.sv
// ============================================================================
//  Module   : alu_mul_seq_if
//  Purpose  : Request/result handshake and external ALU bus for alu_mul_seq.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_mul_seq_if;
    logic       start;
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic       alu_c0;
    logic       alu_il;
    logic       alu_ir;
    logic [3:0] alu_f;
    logic       alu_c8;

    // slave: the multiplier sequencer
    modport slave (
        input  start, mcand, mplier, alu_f, alu_c8,
        output busy, done, product, alu_a, alu_b, alu_s, alu_c0, alu_il, alu_ir
    );

    // master: requester plus the external ALU
    modport master (
        output start, mcand, mplier, alu_f, alu_c8,
        input  busy, done, product, alu_a, alu_b, alu_s, alu_c0, alu_il, alu_ir
    );
endinterface

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
//  Module   : alu_mul_seq
//  Purpose  : 4x4 unsigned shift-add multiplier sequenced over an external ALU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mul_seq #(
    parameter logic [3:0] OP_ADD  = 4'b1001,
    parameter logic [3:0] OP_IDLE = 4'b0000
) (
    input  wire           clk,
    input  wire           rst,
    alu_mul_seq_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q,   state_d;
    logic [1:0] cnt_q,     cnt_d;
    logic [8:0] p_q,       p_d;
    logic [3:0] mcand_q,   mcand_d;
    logic [7:0] product_q, product_d;

    // P[8] is structurally zero; kept for the 9-bit working register width
    logic w_unused_p8;
    assign w_unused_p8 = p_q[8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        mcand_d   = mcand_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    p_d     = {5'b0, bus.mplier};
                    mcand_d = bus.mcand;
                    cnt_d   = 2'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // conditional add into the upper nibble, then shift right by one
                p_d   = {1'b0, bus.alu_c8, bus.alu_f, p_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                product_d = p_q[7:0];
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            p_q       <= 9'd0;
            mcand_q   <= 4'd0;
            product_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == S_CALC) || (state_q == S_DONE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
    assign bus.alu_a   = (state_q == S_CALC) ? p_q[7:4] : 4'h0;
    assign bus.alu_b   = ((state_q == S_CALC) && p_q[0]) ? mcand_q : 4'h0;
    assign bus.alu_s   = (state_q == S_CALC) ? OP_ADD : OP_IDLE;
    assign bus.alu_c0  = 1'b0;
    assign bus.alu_il  = 1'b0;
    assign bus.alu_ir  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ============================================================================
//  Module   : tb_alu_mul_seq
//  Purpose  : Directed and exhaustive self-checking bench for alu_mul_seq.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mul_seq;

    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_IDLE = 4'b0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [7:0] sb[$];

    alu_mul_seq_if bus ();

    alu_mul_seq #(
        .OP_ADD  (OP_ADD),
        .OP_IDLE (OP_IDLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // external ALU: F = A + B + c0 for the add code, pass A otherwise
    assign {bus.alu_c8, bus.alu_f} = (bus.alu_s == OP_ADD)
                                   ? ({1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_c0})
                                   : {1'b0, bus.alu_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp_p;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            exp_p = sb.pop_front();
            check(tag, bus.product, exp_p);
        end
    endtask

    // called at a negedge with the DUT idle; returns at the negedge of cycle 6
    task automatic do_mul(input logic [3:0] a, input logic [3:0] b);
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
        sb.push_back({4'b0, a} * {4'b0, b});
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mcand  = ~a;
        bus.mplier = ~b;
        check("side_inputs_zero", {5'b0, bus.alu_c0, bus.alu_il, bus.alu_ir}, 8'h00);
        for (int k = 0; k < 4; k++) begin
            check("busy_calc",  {7'b0, bus.busy}, 8'h01);
            check("done_calc",  {7'b0, bus.done}, 8'h00);
            check("alu_s_calc", {4'b0, bus.alu_s}, {4'b0, OP_ADD});
            check("alu_b_calc", {4'b0, bus.alu_b}, b[k] ? {4'b0, a} : 8'h00);
            @(negedge clk);
        end
        check("done_pulse", {7'b0, bus.done}, 8'h01);
        check("busy_done",  {7'b0, bus.busy}, 8'h01);
        @(negedge clk);
        check("done_idle",  {7'b0, bus.done}, 8'h00);
        check("busy_idle",  {7'b0, bus.busy}, 8'h00);
        check("alu_s_idle", {4'b0, bus.alu_s}, {4'b0, OP_IDLE});
        check("alu_ab_idle", {bus.alu_a, bus.alu_b}, 8'h00);
        pop_check("product");
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.mcand  = 4'h0;
        bus.mplier = 4'h0;
        #3;
        check("rst_busy",    {7'b0, bus.busy}, 8'h00);
        check("rst_done",    {7'b0, bus.done}, 8'h00);
        check("rst_product", bus.product, 8'h00);
        check("rst_alu_s",   {4'b0, bus.alu_s}, {4'b0, OP_IDLE});
        @(negedge clk);
        rst = 1'b0;

        // first start right after reset release, then corner operands
        do_mul(4'd15, 4'd15);
        check("product_ff", bus.product, 8'hE1);
        do_mul(4'd9,  4'd1);
        do_mul(4'd0,  4'd13);
        do_mul(4'd6,  4'd10);
        check("product_6x10", bus.product, 8'h3C);

        // start held high with operands changing every cycle
        bus.start  = 1'b1;
        bus.mcand  = 4'd3;
        bus.mplier = 4'd5;
        sb.push_back(8'd15);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("hold_done", {7'b0, bus.done}, (c == 5 || c == 11) ? 8'h01 : 8'h00);
            check("hold_busy", {7'b0, bus.busy}, (c == 6 || c == 12) ? 8'h00 : 8'h01);
            if (c == 6 || c == 12) begin
                pop_check("hold_product");
            end
            if (c == 6) begin
                bus.mcand  = 4'd7;
                bus.mplier = 4'd9;
                sb.push_back(8'd63);
            end else begin
                bus.mcand  = 4'($urandom_range(0, 15));
                bus.mplier = 4'($urandom_range(0, 15));
            end
            if (c == 12) begin
                bus.start = 1'b0;
            end
        end

        // asynchronous reset in the middle of CALC
        bus.start  = 1'b1;
        bus.mcand  = 4'd11;
        bus.mplier = 4'd13;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",    {7'b0, bus.busy}, 8'h00);
        check("abort_done",    {7'b0, bus.done}, 8'h00);
        check("abort_product", bus.product, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        check("abort_idle_product", bus.product, 8'h00);
        do_mul(4'd11, 4'd13);

        for (int i = 0; i < 256; i++) begin
            do_mul(4'(i >> 4), 4'(i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
